// File: rtl/pc_gen.sv
// Program-counter generator for the AlicePU fetch stage, with a circular
// return-address stack, a halted state left only by redirect, and stall.
module pc_gen #(
  parameter int          ADDR_W    = 32,
  parameter int          STEP      = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          RAS_DEPTH = 4,
  parameter int          OP_W      = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [OP_W-1:0]                pc_op,
  input  logic                           stall,
  input  logic [25:0]                    imm_J,
  input  logic [15:0]                    imm_I,
  input  logic [ADDR_W-1:0]              rs_jr,
  input  logic                           redirect,
  input  logic [ADDR_W-1:0]              redirect_pc,
  output logic [ADDR_W-1:0]              pc,
  output logic                           halted,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_miss,
  output logic                           ras_ovf
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  localparam logic [OP_W-1:0] OP_IMM_JMP    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_OFFSET_JMP = OP_W'(2);
  localparam logic [OP_W-1:0] OP_REG_JMP    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_HALT       = OP_W'(4);
  localparam logic [OP_W-1:0] OP_CALL       = OP_W'(5);
  localparam logic [OP_W-1:0] OP_RET        = OP_W'(6);
  localparam logic [OP_W-1:0] OP_CALLR      = OP_W'(7);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              halted_reg, halted_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic              miss_reg, miss_next;
  logic              ovf_reg, ovf_next;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] ext;
  logic [ADDR_W-1:0] jt;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic              ras_full;
  logic              push_en;

  assign step     = pc_reg + ADDR_W'(STEP);
  assign ext      = {{(ADDR_W-18){imm_I[15]}}, imm_I, 2'b00};
  assign ptr_inc  = (ptr_reg == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
  assign ptr_dec  = (ptr_reg == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_reg - 1'b1;
  assign ras_full = (cnt_reg == CNT_W'(RAS_DEPTH));

  // The region bits above the 28-bit jump field only exist for ADDR_W > 28.
  generate
    if (ADDR_W > 28) begin : g_jt_region
      assign jt = {pc_reg[ADDR_W-1:28], imm_J, 2'b00};
    end else begin : g_jt_flat
      assign jt = {imm_J, 2'b00};
    end
  endgenerate

  always_comb begin
    pc_next     = pc_reg;
    halted_next = halted_reg;
    cnt_next    = cnt_reg;
    ptr_next    = ptr_reg;
    miss_next   = miss_reg;
    ovf_next    = ovf_reg;
    push_en     = 1'b0;
    if (redirect) begin
      pc_next     = redirect_pc;
      halted_next = 1'b0;
      miss_next   = 1'b0;
      ovf_next    = 1'b0;
    end else if (halted_reg) begin
      // everything, including the pulse registers, holds
    end else if (stall) begin
      miss_next = 1'b0;
      ovf_next  = 1'b0;
    end else begin
      miss_next = 1'b0;
      ovf_next  = 1'b0;
      case (pc_op)
        OP_IMM_JMP:    pc_next = jt;
        OP_OFFSET_JMP: pc_next = step + ext;
        OP_REG_JMP:    pc_next = rs_jr;
        OP_HALT:       halted_next = 1'b1;
        OP_CALL, OP_CALLR: begin
          pc_next  = (pc_op == OP_CALL) ? jt : rs_jr;
          push_en  = 1'b1;
          ptr_next = ptr_inc;
          if (ras_full) ovf_next = 1'b1;
          else          cnt_next = cnt_reg + 1'b1;
        end
        OP_RET: begin
          if (cnt_reg != '0) begin
            pc_next  = ras_mem[ptr_dec];
            ptr_next = ptr_dec;
            cnt_next = cnt_reg - 1'b1;
          end else begin
            pc_next   = rs_jr;
            miss_next = 1'b1;
          end
        end
        default:       pc_next = step;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg     <= ADDR_W'(RESET_PC);
      halted_reg <= 1'b0;
      cnt_reg    <= '0;
      ptr_reg    <= '0;
      miss_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      pc_reg     <= pc_next;
      halted_reg <= halted_next;
      cnt_reg    <= cnt_next;
      ptr_reg    <= ptr_next;
      miss_reg   <= miss_next;
      ovf_reg    <= ovf_next;
      // A push at a full stack lands on the oldest slot, since ptr has wrapped onto it.
      if (push_en) ras_mem[ptr_reg] <= step;
    end
  end

  assign pc        = pc_reg;
  assign halted    = halted_reg;
  assign ras_count = cnt_reg;
  assign ras_miss  = miss_reg;
  assign ras_ovf   = ovf_reg;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus random traffic, checked against a
// queue-based reference model of the PC and return-address stack.
module tb_pc_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pc_op;
  logic        stall;
  logic [25:0] imm_J;
  logic [15:0] imm_I;
  logic [31:0] rs_jr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        halted;
  logic [2:0]  ras_count;
  logic        ras_miss;
  logic        ras_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_halted;
  logic        m_miss;
  logic        m_ovf;
  logic [31:0] m_ras[$];

  pc_gen #(
    .ADDR_W(32), .STEP(4), .RESET_PC(32'h0000_3000), .RAS_DEPTH(DEPTH), .OP_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_op(pc_op), .stall(stall),
    .imm_J(imm_J), .imm_I(imm_I), .rs_jr(rs_jr),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .halted(halted), .ras_count(ras_count),
    .ras_miss(ras_miss), .ras_ovf(ras_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, 64'(pc), 64'(m_pc));
    chk({tag, ".halted"}, 64'(halted), 64'(m_halted));
    chk({tag, ".count"}, 64'(ras_count), 64'(m_ras.size()));
    chk({tag, ".miss"}, 64'(ras_miss), 64'(m_miss));
    chk({tag, ".ovf"}, 64'(ras_ovf), 64'(m_ovf));
  endtask

  task automatic model_reset();
    m_pc = 32'h3000; m_halted = 0; m_miss = 0; m_ovf = 0;
    m_ras.delete();
  endtask

  task automatic model_push(input logic [31:0] a);
    m_ras.push_back(a);
    if (m_ras.size() > DEPTH) begin
      void'(m_ras.pop_front());
      m_ovf = 1;
    end
  endtask

  task automatic model_edge();
    logic [31:0] nxt;
    logic [31:0] tgt;
    int off;
    nxt = m_pc + 32'd4;
    tgt = {m_pc[31:28], imm_J, 2'b00};
    if (redirect) begin
      m_pc = redirect_pc; m_halted = 0; m_miss = 0; m_ovf = 0;
    end else if (m_halted) begin
    end else begin
      m_miss = 0; m_ovf = 0;
      if (!stall) begin
        case (pc_op)
          3'd0: m_pc = nxt;
          3'd1: m_pc = tgt;
          3'd2: begin off = $signed(imm_I); m_pc = nxt + 32'(off * 4); end
          3'd3: m_pc = rs_jr;
          3'd4: m_halted = 1;
          3'd5: begin model_push(nxt); m_pc = tgt; end
          3'd7: begin model_push(nxt); m_pc = rs_jr; end
          default: begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = rs_jr; m_miss = 1; end
          end
        endcase
      end
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic st, input logic [25:0] j,
                       input logic [15:0] i, input logic [31:0] rs);
    pc_op = op; stall = st; imm_J = j; imm_I = i; rs_jr = rs; redirect = 0;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    $display("%s op=%0d stall=%0b redir=%0b pc=%08h halted=%0b cnt=%0d miss=%0b ovf=%0b",
             tag, pc_op, stall, redirect, pc, halted, ras_count, ras_miss, ras_ovf);
    chk_all(tag);
  endtask

  task automatic hard_reset();
    @(posedge clk);
    #2;
    rst_n = 0;
    #2;
    model_reset();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    drive(3'd0, 0, 26'd0, 16'd0, 32'd0);
    redirect_pc = 32'd0;
    #12;
    model_reset();
    rst_n = 1;
    chk("reset.pc", 64'(pc), 64'h3000);
    chk("reset.halted", 64'(halted), 64'd0);
    chk("reset.count", 64'(ras_count), 64'd0);
    chk("reset.pulses", 64'({ras_miss, ras_ovf}), 64'd0);

    // 1: sequential stepping
    drive(3'd0, 0, 26'd0, 16'd0, 32'd0);
    for (int k = 0; k < 3; k++) tick("t1_next");
    chk("t1.pc", 64'(pc), 64'h300C);

    // 2: call then return
    hard_reset();
    drive(3'd5, 0, 26'h0000C40, 16'd0, 32'd0); tick("t2_call");
    chk("t2.call_pc", 64'(pc), 64'h3100);
    chk("t2.call_cnt", 64'(ras_count), 64'd1);
    drive(3'd6, 0, 26'd0, 16'd0, 32'hDEAD_0000); tick("t2_ret");
    chk("t2.ret_pc", 64'(pc), 64'h3004);
    chk("t2.ret_cnt", 64'(ras_count), 64'd0);

    // 3: relative branches
    drive(3'd3, 0, 26'd0, 16'd0, 32'h3010); tick("t3_jr");
    drive(3'd2, 0, 26'd0, 16'hFFFF, 32'd0); tick("t3_off_neg");
    chk("t3.self_loop", 64'(pc), 64'h3010);
    drive(3'd2, 0, 26'd0, 16'h0004, 32'd0); tick("t3_off_pos");
    chk("t3.fwd", 64'(pc), 64'h3024);

    // 4: stack overflow and underflow
    hard_reset();
    for (int k = 0; k < 5; k++) begin
      drive(3'd5, 0, 26'h0000C40 + 26'(k * 'h40), 16'd0, 32'd0);
      tick("t4_call");
    end
    chk("t4.ovf", 64'(ras_ovf), 64'd1);
    chk("t4.cnt_full", 64'(ras_count), 64'd4);
    for (int k = 0; k < 4; k++) begin
      drive(3'd6, 0, 26'd0, 16'd0, 32'h4000);
      tick("t4_ret");
    end
    chk("t4.last_ret", 64'(pc), 64'h3104);
    drive(3'd6, 0, 26'd0, 16'd0, 32'h4000); tick("t4_ret_empty");
    chk("t4.miss_pc", 64'(pc), 64'h4000);
    chk("t4.miss", 64'(ras_miss), 64'd1);
    drive(3'd0, 0, 26'd0, 16'd0, 32'd0); tick("t4_after");
    chk("t4.miss_clr", 64'(ras_miss), 64'd0);

    // 5: halt, ignore ops, leave via redirect
    drive(3'd7, 0, 26'd0, 16'd0, 32'h3020); tick("t5_callr");
    drive(3'd4, 0, 26'd0, 16'd0, 32'd0); tick("t5_halt");
    chk("t5.halted", 64'(halted), 64'd1);
    for (int k = 0; k < 10; k++) begin
      drive((k % 2) ? 3'd5 : 3'd0, 0, 26'h123, 16'd0, 32'd0);
      tick("t5_hold");
    end
    chk("t5.hold_pc", 64'(pc), 64'h3020);
    chk("t5.hold_cnt", 64'(ras_count), 64'd1);
    drive(3'd0, 1, 26'd0, 16'd0, 32'd0);
    redirect = 1; redirect_pc = 32'h8000_0180; tick("t5_redirect");
    chk("t5.redir_pc", 64'(pc), 64'h8000_0180);
    chk("t5.redir_halted", 64'(halted), 64'd0);

    // 6: stall freezes, async reset mid-sequence
    hard_reset();
    for (int k = 0; k < 3; k++) begin
      drive(3'd5, 1, 26'h0000C40, 16'd0, 32'd0);
      tick("t6_stall");
    end
    chk("t6.frozen_pc", 64'(pc), 64'h3000);
    chk("t6.frozen_cnt", 64'(ras_count), 64'd0);
    drive(3'd5, 0, 26'h0000C40, 16'd0, 32'd0); tick("t6_call");
    drive(3'd5, 1, 26'h0000C40, 16'd0, 32'd0); tick("t6_stall2");
    #2;
    rst_n = 0;
    #1;
    chk("t6.async_pc", 64'(pc), 64'h3000);
    chk("t6.async_cnt", 64'(ras_count), 64'd0);
    model_reset();
    #1;
    rst_n = 1;

    // random traffic
    for (int k = 0; k < 600; k++) begin
      drive(3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0),
            26'($urandom), 16'($urandom), $urandom & 32'hFFFF_FFFC);
      if (pc_op == 3'd4 && $urandom_range(0, 2) != 0) pc_op = 3'd0;
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
